// File: rtl/mem_writer_if.sv
// Element-pair input stream for mem_writer: valid/ready handshake carrying
// one element for mem1 (data_a) and one for mem2 (data_b).
interface mem_writer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_a;
   logic [DATA_WIDTH-1:0] data_b;

   modport master (
      output in_valid,
      output data_a,
      output data_b,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  data_a,
      input  data_b,
      output in_ready
   );
endinterface

// File: rtl/mem_writer.sv
// Loads one vector pair into two memories: each accepted element pair is
// written to mem1/mem2 at its element index on the following cycle.
module mem_writer #(
   parameter int DATA_WIDTH   = 8,
   parameter int VECTOR_WIDTH = 4,
   parameter int ADDR_WIDTH   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_writing,
   mem_writer_if.slave           in_bus,
   output logic                  wr_en_mem1,
   output logic                  wr_en_mem2,
   output logic [ADDR_WIDTH-1:0] wr_addr_mem1,
   output logic [ADDR_WIDTH-1:0] wr_addr_mem2,
   output logic [DATA_WIDTH-1:0] wr_data_mem1,
   output logic [DATA_WIDTH-1:0] wr_data_mem2,
   output logic                  writing_done,
   output logic [2:0]            element_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [2:0] LAST_IDX = 3'(VECTOR_WIDTH - 1);

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic                  in_ready_r;
   logic                  wr_en_r;
   logic                  done_r;
   logic [2:0]            count_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] data_a_r;
   logic [DATA_WIDTH-1:0] data_b_r;
   logic                  accept_s;
   logic                  last_s;

   // Handshake decode: the final accept is the one at index VECTOR_WIDTH-1.
   always_comb begin
      accept_s = in_bus.in_valid & in_ready_r;
      if (accept_s && (count_r == LAST_IDX)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Next-state logic; start requests outside IDLE are dropped, not queued.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_writing) begin
               state_nxt_s = WRITE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WRITE: begin
            if (last_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WRITE;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, handshake and write-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b0;
         wr_en_r    <= 1'b0;
         done_r     <= 1'b0;
         count_r    <= 3'd0;
         addr_r     <= '0;
         data_a_r   <= '0;
         data_b_r   <= '0;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s == WRITE);
         wr_en_r    <= accept_s;
         // done lands on the same cycle as the final strobe
         done_r     <= last_s;
         if (accept_s) begin
            addr_r   <= ADDR_WIDTH'(count_r);
            data_a_r <= in_bus.data_a;
            data_b_r <= in_bus.data_b;
            count_r  <= count_r + 3'd1;
         end else if ((state_r == IDLE) && start_writing) begin
            count_r <= 3'd0;
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign in_bus.in_ready = in_ready_r;
   assign wr_en_mem1      = wr_en_r;
   assign wr_en_mem2      = wr_en_r;
   assign wr_addr_mem1    = addr_r;
   assign wr_addr_mem2    = addr_r;
   assign wr_data_mem1    = data_a_r;
   assign wr_data_mem2    = data_b_r;
   assign writing_done    = done_r;
   assign element_count   = count_r;

endmodule

// File: tb/tb_mem_writer.sv
// Self-checking bench for mem_writer: per-cycle vector table plus a
// write scoreboard, followed by a start-to-done latency sequence.
module tb_mem_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_writing;
   logic       wr_en_mem1, wr_en_mem2, writing_done;
   logic [4:0] wr_addr_mem1, wr_addr_mem2;
   logic [7:0] wr_data_mem1, wr_data_mem2;
   logic [2:0] element_count;

   mem_writer_if #(.DATA_WIDTH(8)) bus ();

   mem_writer #(.DATA_WIDTH(8), .VECTOR_WIDTH(4), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .start_writing(start_writing), .in_bus(bus),
      .wr_en_mem1(wr_en_mem1), .wr_en_mem2(wr_en_mem2),
      .wr_addr_mem1(wr_addr_mem1), .wr_addr_mem2(wr_addr_mem2),
      .wr_data_mem1(wr_data_mem1), .wr_data_mem2(wr_data_mem2),
      .writing_done(writing_done), .element_count(element_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic       start;
      logic       valid;
      logic [7:0] a;
      logic [7:0] b;
      logic       rdy;
      logic       wr;
      logic       done;
      logic [2:0] cnt;
      logic       zero;
   } row_t;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   row_t rows[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic row_t mk(input logic r, input logic s, input logic v,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic rdy, input logic wr, input logic dn,
                               input logic [2:0] cnt, input logic z);
      row_t t;
      t = '{rst: r, start: s, valid: v, a: a, b: b, rdy: rdy, wr: wr,
            done: dn, cnt: cnt, zero: z};
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en1"}, 32'(wr_en_mem1), 32'd0);
      chk({tag, "_wr_en2"}, 32'(wr_en_mem2), 32'd0);
      chk({tag, "_addr1"}, 32'(wr_addr_mem1), 32'd0);
      chk({tag, "_addr2"}, 32'(wr_addr_mem2), 32'd0);
      chk({tag, "_data1"}, 32'(wr_data_mem1), 32'd0);
      chk({tag, "_data2"}, 32'(wr_data_mem2), 32'd0);
      chk({tag, "_done"}, 32'(writing_done), 32'd0);
      chk({tag, "_count"}, 32'(element_count), 32'd0);
      chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   cyc;
      // rows: rst start valid a b | in_ready wr_en done count zero-check
      // full load with in_valid held high
      rows.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd1, 8'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd2, 8'd6, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd3, 8'd7, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd4, 8'd8, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0));
      // in_valid in IDLE without start
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      // start with in_valid high, then 2-cycle stall after second pair
      rows.push_back(mk(1'b0, 1'b1, 1'b1, 8'd7, 8'd7, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd1, 8'd5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd2, 8'd6, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd3, 8'd7, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b1, 1'b1, 8'd4, 8'd8, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0));
      rows.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0));
      // back-to-back load, start pulse at element 2 ignored
      rows.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA1, 8'hB1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA2, 8'hB2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
      rows.push_back(mk(1'b0, 1'b1, 1'b1, 8'hA3, 8'hB3, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA4, 8'hB4, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      // reset after two accepts, then a fresh load from address 0
      rows.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd7, 8'd8, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
      rows.push_back(mk(1'b1, 1'b0, 1'b1, 8'd9, 8'd10, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd9, 8'd10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
      rows.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd11, 8'd12, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd13, 8'd14, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd15, 8'd16, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b1, 8'd17, 8'd18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0));
      rows.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));

      rst = 1'b1;
      start_writing = 1'b0;
      bus.in_valid = 1'b0;
      bus.data_a = 8'd0;
      bus.data_b = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");

      foreach (rows[i]) begin
         @(posedge clk);
         #1;
         rst = rows[i].rst;
         start_writing = rows[i].start;
         bus.in_valid = rows[i].valid;
         bus.data_a = rows[i].a;
         bus.data_b = rows[i].b;
         if (rows[i].rdy && rows[i].valid && !rows[i].rst) begin
            sb.push_back('{addr: 5'(rows[i].cnt), a: rows[i].a, b: rows[i].b});
         end
         @(negedge clk);
         chk($sformatf("ready_r%0d", i), 32'(bus.in_ready), 32'(rows[i].rdy));
         chk($sformatf("wr_en1_r%0d", i), 32'(wr_en_mem1), 32'(rows[i].wr));
         chk($sformatf("wr_en2_r%0d", i), 32'(wr_en_mem2), 32'(rows[i].wr));
         chk($sformatf("done_r%0d", i), 32'(writing_done), 32'(rows[i].done));
         chk($sformatf("count_r%0d", i), 32'(element_count), 32'(rows[i].cnt));
         if (rows[i].zero) begin
            chk_zero($sformatf("post_rst_r%0d", i));
         end
         if (wr_en_mem1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_write_r%0d actual=write required=none", i);
            end else begin
               e = sb.pop_front();
               chk($sformatf("addr1_r%0d", i), 32'(wr_addr_mem1), 32'(e.addr));
               chk($sformatf("addr2_r%0d", i), 32'(wr_addr_mem2), 32'(e.addr));
               chk($sformatf("data1_r%0d", i), 32'(wr_data_mem1), 32'(e.a));
               chk($sformatf("data2_r%0d", i), 32'(wr_data_mem2), 32'(e.b));
            end
         end
      end
      chk("sb_leftover", 32'(sb.size()), 32'd0);

      // address/data hold the last write while strobes are low
      chk("hold_addr1", 32'(wr_addr_mem1), 32'd3);
      chk("hold_data1", 32'(wr_data_mem1), 32'd17);
      chk("hold_data2", 32'(wr_data_mem2), 32'd18);

      // minimum start -> writing_done latency is VECTOR_WIDTH+1 cycles
      @(posedge clk);
      #1;
      start_writing = 1'b1;
      bus.in_valid = 1'b1;
      bus.data_a = 8'h55;
      bus.data_b = 8'h66;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         start_writing = 1'b0;
         cyc++;
         @(negedge clk);
         if (writing_done) break;
      end
      chk("latency", 32'(cyc), 32'd5);
      chk("latency_count", 32'(element_count), 32'd4);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("latency_done_pulse", 32'(writing_done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
